input_conditioner: RTL



---
 rtl/input_conditioner.sv | 76 +++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: synchroniser chain, per-channel debounce, optional edge pulses.
// Define INPUT_COND_EDGE_EN to build the rise/fall pulse registers; otherwise rise/fall are tied low.
module input_conditioner #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      STAGES          = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE   = '0
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] out_d;

    assign s = sync_q[STAGES-1];

    // Plain flop chain; only the first stage may see metastability.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int k = 0; k < STAGES; k++) sync_q[k] <= DEFAULT_VALUE;
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Any cycle where s matches out restarts the filter; a full run of mismatches commits s.
    always_comb begin
        out_d = out;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != out[i]) begin
                if (cnt_q[i] == CNT_MAX) out_d[i] = s[i];
                else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            out <= DEFAULT_VALUE;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            out <= out_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef INPUT_COND_EDGE_EN
    // Pulses land on the same edge as the out change.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= out_d & ~out;
            fall <= ~out_d & out;
        end
    end
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule
